// File: rtl/event_encoder32_if.sv
// event_encoder32_if: groups the event inputs, the index handshake and the
// status outputs of event_encoder32. The master side is the encoder, which
// drives the index, status and pending outputs. The slave side is the
// consumer/source side.
interface event_encoder32_if #(
  parameter int unsigned IDX_W = 5
);
  localparam int unsigned N = 2**IDX_W;

  logic [N-1:0]     req;
  logic             enable;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pending;
  logic             busy;

  modport master (
    input  req, enable, out_ready,
    output out_valid, out_idx, pending, busy
  );

  modport slave (
    output req, enable, out_ready,
    input  out_valid, out_idx, pending, busy
  );
endinterface

// File: rtl/event_encoder32.sv
// event_encoder32: sequential 2**IDX_W-to-IDX_W encoder.
// Event lines are captured into a sticky pending vector. Pending indices are
// issued one at a time over a valid/ready handshake, and each bit is cleared
// from pending as it moves into the output stage.
// Optional macro EVENT_ENC_RR_PRIORITY_EN selects round-robin arbitration.
// The search starts after the last issued index. Without the macro, the
// lowest pending index wins and no pointer register exists.
module event_encoder32 #(
  parameter int unsigned IDX_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  event_encoder32_if.master  bus
);
  localparam int unsigned N = 2**IDX_W;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]     set_vec;
  logic [N-1:0]     load_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             stage_free;
  logic             load;

`ifdef EVENT_ENC_RR_PRIORITY_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Round-robin search over pending, starting at ptr+1 and wrapping modulo N.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end
`else
  // Fixed-priority search over pending: the lowest set index wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!sel_found && pending_q[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // Next-state logic: capture, load into the output stage, and the handshake FSM.
  always_comb begin
    stage_free = (state_q == EMPTY) || bus.out_ready;
    load       = stage_free && sel_found;
    load_mask  = load ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
    set_vec    = bus.enable ? bus.req : '0;
    // A new set of bit k at the edge where k loads keeps k pending.
    pending_d  = (pending_q & ~load_mask) | set_vec;
    out_idx_d  = load ? sel_idx : out_idx_q;
    state_d    = state_q;
    case (state_q)
      EMPTY: if (sel_found) state_d = FULL;
      FULL:  if (bus.out_ready) state_d = sel_found ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

`ifdef EVENT_ENC_RR_PRIORITY_EN
  // Pointer tracks the last issued index. The reset value makes the first search start at 0.
  always_comb begin
    ptr_d = load ? sel_idx : ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '1;
    else          ptr_q <= ptr_d;
  end
`endif

  // State, pending and output-stage registers. Reset discards everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_idx   = out_idx_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = (|pending_q) || (state_q == FULL);

endmodule
